// File: rtl/countdown_timer.sv
// Hours:minutes:seconds down-counter with switch preset, hold, expiry pulse and timed buzzer.
// Registered outputs; one edge from switch/tick to count/state update, synchronous active-low reset.
module countdown_timer #(
  parameter int H_MAX     = 24,
  parameter int M_MAX     = 60,
  parameter int ALARM_LEN = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [17:0] SW,
  output logic [4:0]  hour,
  output logic [5:0]  minute,
  output logic [5:0]  second,
  output logic        running,
  output logic        done,
  output logic        buzz
);

  localparam logic [4:0] H_TOP = 5'(H_MAX - 1);
  localparam logic [5:0] M_TOP = 6'(M_MAX - 1);
  localparam int         AW    = $clog2(ALARM_LEN + 1);
  localparam logic [AW-1:0] A_LAST = AW'(ALARM_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, EXPIRED} state_t;

  state_t        state_q;
  logic [4:0]    hour_q;
  logic [5:0]    minute_q, second_q;
  logic          running_q, done_q, buzz_q;
  logic [AW-1:0] alarm_q;

  logic          hold, load, ack;
  logic [4:0]    load_hr_d;
  logic [5:0]    load_min_d;
  logic          load_zero_d;
  logic [4:0]    hour_d;
  logic [5:0]    minute_d, second_d;
  logic          last_sec_d;
  logic          unused_sw;

  assign hold      = SW[0];
  assign load      = SW[1];
  assign ack       = SW[13];
  assign unused_sw = ^SW[17:14];

  always_comb begin
    load_hr_d   = (SW[12:8] > H_TOP) ? H_TOP : SW[12:8];
    load_min_d  = (SW[7:2]  > M_TOP) ? M_TOP : SW[7:2];
    load_zero_d = (load_hr_d == 5'd0) && (load_min_d == 6'd0);
    last_sec_d  = (hour_q == 5'd0) && (minute_q == 6'd0) && (second_q == 6'd1);
  end

  // Borrow chain; only used in RUN where the count is known to be nonzero.
  always_comb begin
    hour_d   = hour_q;
    minute_d = minute_q;
    second_d = second_q - 6'd1;
    if (second_q == 6'd0) begin
      second_d = M_TOP;
      if (minute_q == 6'd0) begin
        minute_d = M_TOP;
        hour_d   = hour_q - 5'd1;
      end else begin
        minute_d = minute_q - 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      hour_q    <= '0;
      minute_q  <= '0;
      second_q  <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      buzz_q    <= 1'b0;
      alarm_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        hour_q   <= load_hr_d;
        minute_q <= load_min_d;
        second_q <= '0;
        buzz_q   <= 1'b0;
        alarm_q  <= '0;
        if (load_zero_d) begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end else if (hold) begin
          state_q   <= HOLD;
          running_q <= 1'b0;
        end else begin
          state_q   <= RUN;
          running_q <= 1'b1;
        end
      end else begin
        case (state_q)
          RUN: begin
            if (hold) begin
              state_q   <= HOLD;
              running_q <= 1'b0;
            end else if (tick) begin
              if (last_sec_d) begin
                second_q  <= '0;
                state_q   <= EXPIRED;
                running_q <= 1'b0;
                done_q    <= 1'b1;
                buzz_q    <= 1'b1;
                alarm_q   <= '0;
              end else begin
                hour_q   <= hour_d;
                minute_q <= minute_d;
                second_q <= second_d;
              end
            end
          end
          HOLD: begin
            if (!hold) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end
          EXPIRED: begin
            if (ack) begin
              state_q <= IDLE;
              buzz_q  <= 1'b0;
              alarm_q <= '0;
            end else if (tick) begin
              if (alarm_q == A_LAST) begin
                state_q <= IDLE;
                buzz_q  <= 1'b0;
                alarm_q <= '0;
              end else begin
                alarm_q <= alarm_q + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign hour    = hour_q;
  assign minute  = minute_q;
  assign second  = second_q;
  assign running = running_q;
  assign done    = done_q;
  assign buzz    = buzz_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: total-seconds reference model checked every cycle, plus literal spot checks.
module tb_countdown_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [17:0] SW;
  logic [4:0]  hour;
  logic [5:0]  minute, second;
  logic        running, done, buzz;

  int checks = 0;
  int errors = 0;

  countdown_timer #(.H_MAX(24), .M_MAX(60), .ALARM_LEN(10)) dut (
    .clk(clk), .rst(rst), .tick(tick), .SW(SW),
    .hour(hour), .minute(minute), .second(second),
    .running(running), .done(done), .buzz(buzz)
  );

  always #5 clk = ~clk;

  // Reference model: remaining time as a single seconds count, mode 0 idle / 1 run / 2 hold / 3 expired
  int  m_rem   = 0;
  int  m_mode  = 0;
  int  m_alarm = 0;
  bit  m_done  = 0;

  always @(posedge clk) begin
    int h, m;
    m_done = 0;
    if (!rst) begin
      m_rem = 0; m_mode = 0; m_alarm = 0;
    end else if (SW[1]) begin
      h = (int'(SW[12:8]) > 23) ? 23 : int'(SW[12:8]);
      m = (int'(SW[7:2])  > 59) ? 59 : int'(SW[7:2]);
      m_rem   = h * 3600 + m * 60;
      m_mode  = (m_rem == 0) ? 0 : (SW[0] ? 2 : 1);
      m_alarm = 0;
    end else if (m_mode == 3) begin
      if (SW[13]) begin
        m_mode = 0; m_alarm = 0;
      end else if (tick) begin
        m_alarm++;
        if (m_alarm == 10) begin m_mode = 0; m_alarm = 0; end
      end
    end else if (m_mode == 1) begin
      if (SW[0]) m_mode = 2;
      else if (tick) begin
        m_rem--;
        if (m_rem == 0) begin m_mode = 3; m_done = 1; end
      end
    end else if (m_mode == 2) begin
      if (!SW[0]) m_mode = 1;
    end
  end

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cmp("model_hour",    int'(hour),    m_rem / 3600);
    cmp("model_minute",  int'(minute),  (m_rem / 60) % 60);
    cmp("model_second",  int'(second),  m_rem % 60);
    cmp("model_running", int'(running), int'(m_mode == 1));
    cmp("model_done",    int'(done),    int'(m_done));
    cmp("model_buzz",    int'(buzz),    int'(m_mode == 3));
  end

  function automatic logic [17:0] swv(input bit hold, input bit load, input int mn,
                                      input int hr, input bit ack);
    logic [17:0] v;
    v = '0;
    v[0] = hold;
    v[1] = load;
    v[7:2] = 6'(mn);
    v[12:8] = 5'(hr);
    v[13] = ack;
    return v;
  endfunction

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tk();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin tk(); gap(1); end
  endtask

  task automatic hms(input string nm, input int h, input int m, input int s);
    cmp({nm, "_hour"},   int'(hour),   h);
    cmp({nm, "_minute"}, int'(minute), m);
    cmp({nm, "_second"}, int'(second), s);
  endtask

  task automatic load(input int mn, input int hr, input bit hold);
    SW = swv(hold, 1'b1, mn, hr, 1'b0);
    gap(1);
    SW = swv(hold, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; SW = '0;
    gap(2);
    hms("reset", 0, 0, 0);
    cmp("reset_running", int'(running), 0);
    cmp("reset_buzz", int'(buzz), 0);
    rst = 1'b1;
    gap(1);

    // 1. one-minute countdown to expiry
    load(1, 0, 1'b0);
    hms("load1m", 0, 1, 0);
    cmp("load1m_running", int'(running), 1);
    tk();
    hms("tick1", 0, 0, 59);
    gap(1);
    ticks(58);
    hms("tick59", 0, 0, 1);
    tk();
    cmp("expire_done", int'(done), 1);
    cmp("expire_buzz", int'(buzz), 1);
    hms("expire", 0, 0, 0);
    gap(1);
    cmp("done_one_cycle", int'(done), 0);

    // 5a. buzzer times out after ten ticks
    ticks(9);
    cmp("alarm9_buzz", int'(buzz), 1);
    tk();
    cmp("alarm10_buzz", int'(buzz), 0);
    gap(1);
    ticks(2);
    hms("idle_ignores_tick", 0, 0, 0);

    // 2. double borrow from one hour
    load(0, 1, 1'b0);
    hms("load1h", 1, 0, 0);
    tk();
    hms("borrow", 0, 59, 59);
    cmp("borrow_running", int'(running), 1);
    gap(1);

    // 4. hold wins over a same-cycle tick
    SW = swv(1'b1, 1'b0, 0, 0, 1'b0);
    tick = 1'b1;
    gap(1);
    tick = 1'b0;
    hms("hold_tick", 0, 59, 59);
    cmp("hold_running", int'(running), 0);
    SW = '0;
    gap(1);
    cmp("resume_running", int'(running), 1);
    tk();
    hms("resume_dec", 0, 59, 58);
    gap(1);

    // load held high reloads every cycle, ticks do not decrement
    SW = swv(1'b0, 1'b1, 2, 0, 1'b0);
    ticks(3);
    hms("load_held", 0, 2, 0);
    SW = '0;

    // 3. clamp with hold asserted
    load(63, 31, 1'b1);
    hms("clamp", 23, 59, 0);
    cmp("clamp_running", int'(running), 0);
    ticks(2);
    hms("hold_frozen", 23, 59, 0);
    SW = '0;
    gap(1);

    // 5b. acknowledge silences the buzzer
    load(1, 0, 1'b0);
    ticks(60);
    cmp("expire2_buzz", int'(buzz), 1);
    ticks(3);
    SW = swv(1'b0, 1'b0, 0, 0, 1'b1);
    gap(1);
    SW = '0;
    cmp("ack_buzz", int'(buzz), 0);
    cmp("ack_running", int'(running), 0);
    gap(1);

    // load during expiry aborts the alarm
    load(1, 0, 1'b0);
    ticks(60);
    cmp("expire3_buzz", int'(buzz), 1);
    load(3, 0, 1'b0);
    cmp("abort_buzz", int'(buzz), 0);
    hms("abort_load", 0, 3, 0);

    // 6. synchronous reset mid-run
    load(11, 0, 1'b0);
    ticks(55);
    hms("pre_reset", 0, 10, 5);
    rst = 1'b0;
    tick = 1'b1;
    gap(1);
    rst = 1'b1;
    tick = 1'b0;
    hms("midrun_reset", 0, 0, 0);
    cmp("midrun_reset_running", int'(running), 0);
    cmp("midrun_reset_done", int'(done), 0);

    load(2, 0, 1'b0);
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    gap(1);
    hms("rst_glitch", 0, 2, 0);
    cmp("rst_glitch_running", int'(running), 1);
    gap(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
